// File: rtl/sm4_ctrl.sv
// sm4_ctrl: job sequencer in front of an sm4_top cipher core.
// Takes one request at a time, presents key/data to the core, waits for
// key expansion, starts the cipher, then holds the result on a valid/ready
// response port until the requester takes it.
//
// Build option: define SM4_CTRL_WDOG_EN to bound each core wait (KEYWAIT and
// RUN) to WDOG_CYCLES cycles. A timed-out job returns rsp_data=0, rsp_err=1
// and is not counted in jobs_done. Without the macro both waits are unbounded
// and rsp_err is constant 0.
//
// state   | meaning
// IDLE    | ready for a request, req_ready=1
// LOAD    | one-cycle core_load pulse, key/data presented to the core
// KEYWAIT | waiting for key expansion; first cycle ignores a stale ready
// START   | one-cycle core_start pulse
// RUN     | waiting for the cipher result; first cycle ignores a stale ready
// RESP    | result held with rsp_valid=1 until rsp_ready
module sm4_ctrl #(
  parameter int WDOG_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  // requester side
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_decrypt,
  input  logic [127:0] req_data,
  input  logic [127:0] req_key,
  // response side
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [15:0]  jobs_done,
  // core side
  output logic         core_load,
  output logic         core_start,
  output logic         core_sel,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic         core_key_ready,
  input  logic         core_ready,
  input  logic [127:0] core_result
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_KEYWAIT = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  // The first-cycle ignore and the watchdog compare both assume at least two
  // cycles of wait are allowed.
  if (WDOG_CYCLES < 2) begin : g_wdog_range
    $error("sm4_ctrl: WDOG_CYCLES must be at least 2");
  end

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic         first_q;
  logic         hold_sel;
  logic [127:0] hold_data;
  logic [127:0] hold_key;
  logic [127:0] rsp_data_q;
  logic [15:0]  jobs_q;
  logic         key_done;
  logic         run_done;
  logic         wdog_to;

  // Ready is only trusted after the first cycle in each wait state, because
  // the core leaves its ready flags high from the previous job.
  assign key_done = (state == S_KEYWAIT) && !first_q && core_key_ready;
  assign run_done = (state == S_RUN)     && !first_q && core_ready;

`ifdef SM4_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_expired;
  logic              rsp_err_q;

  // The count holds the number of cycles already spent in the wait state,
  // so the last permitted cycle is WDOG_CYCLES-1 and the exit edge makes it
  // WDOG_CYCLES. A ready on that same cycle wins over the timeout.
  assign wdog_expired = ((state == S_KEYWAIT) || (state == S_RUN)) &&
                        (wdog_cnt == WDOG_LAST);
  assign wdog_to      = wdog_expired && !key_done && !run_done;

  // Watchdog counter: cleared on the way into each wait state, counts inside.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if ((state == S_KEYWAIT) || (state == S_RUN)) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

  // Error flag: cleared by a real result, set by a timeout, held through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (run_done) begin
      rsp_err_q <= 1'b0;
    end else if (wdog_to) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign wdog_to = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_KEYWAIT;
      end
      S_KEYWAIT: begin
        if (key_done) begin
          state_nxt = S_START;
        end else if (wdog_to) begin
          state_nxt = S_RESP;
        end
      end
      S_START: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (run_done || wdog_to) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus the first-cycle marker for the two wait states.
  // LOAD and START always lead into KEYWAIT and RUN, so the marker is simply
  // "previous state was LOAD or START".
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      first_q <= (state == S_LOAD) || (state == S_START);
    end
  end

  // Request holding registers; they feed the core directly and only change
  // when a new job is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_sel  <= 1'b0;
      hold_data <= '0;
      hold_key  <= '0;
    end else if ((state == S_IDLE) && req_valid) begin
      hold_sel  <= req_decrypt;
      hold_data <= req_data;
      hold_key  <= req_key;
    end
  end

  // Result register: core output on completion, zero on a watchdog abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data_q <= '0;
    end else if (run_done) begin
      rsp_data_q <= core_result;
    end else if (wdog_to) begin
      rsp_data_q <= '0;
    end
  end

  // Completed-job counter; only successful handshakes count, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      jobs_q <= '0;
    end else if ((state == S_RESP) && rsp_ready && !rsp_err) begin
      jobs_q <= jobs_q + 16'd1;
    end
  end

  // req_ready is gated by reset so it stays low for the whole reset window,
  // including the cycle before the first clock edge has moved the FSM.
  assign req_ready  = (state == S_IDLE) && !reset;
  assign rsp_valid  = (state == S_RESP);
  assign rsp_data   = rsp_data_q;
  assign jobs_done  = jobs_q;
  assign core_load  = (state == S_LOAD);
  assign core_start = (state == S_START);
  assign core_sel   = hold_sel;
  assign core_data  = hold_data;
  assign core_key   = hold_key;

endmodule

// File: tb/tb_sm4_ctrl.sv
// tb_sm4_ctrl: directed plus randomized bench for sm4_ctrl. The cipher core
// is a behavioural stand-in for sm4_top: it computes SM4 from the algorithm
// definition and answers with a random handshake delay, leaving its ready
// flags and result stale between jobs the way the real core does.
module tb_sm4_ctrl;

  localparam int WDOG = 255;
  localparam logic [127:0] K0 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] C0 = 128'h681EDF34D206965E86B3E94F536E4246;
  localparam logic [127:0] K3 = 128'h33333333333333333333333333333333;

  localparam logic [7:0] SBOX [0:255] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };
  localparam logic [31:0] FK [0:3] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_decrypt = 1'b0;
  logic [127:0] req_data = '0;
  logic [127:0] req_key = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [15:0]  jobs_done;
  logic         core_load;
  logic         core_start;
  logic         core_sel;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic         core_key_ready = 1'b0;
  logic         core_ready = 1'b0;
  logic [127:0] core_result = '0;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_jobs = '0;

  sm4_ctrl #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .jobs_done(jobs_done),
    .core_load(core_load), .core_start(core_start), .core_sel(core_sel),
    .core_data(core_data), .core_key(core_key),
    .core_key_ready(core_key_ready), .core_ready(core_ready), .core_result(core_result)
  );

  always #5 clk = ~clk;

  // ---------------- SM4 reference ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic logic [127:0] sm4_ref(input logic [127:0] key, input logic [127:0] din,
                                           input logic dec);
    logic [31:0] k [0:35];
    logic [31:0] x [0:35];
    logic [31:0] rk [0:31];
    logic [31:0] ck;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127 - 32*i -: 32] ^ FK[i];
      x[i] = din[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'((4*i + j) * 7);
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk[i]  = k[i+4];
    end
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]));
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- core stand-in ----------------
  // Acts on the falling edge so its outputs are settled for the DUT's rising
  // edge. The cycle right after each pulse leaves ready (and result) as they
  // were from the previous job; the ready then rises on wait cycle Nk / Nr.
  int k_cnt = 0, r_cnt = 0, last_dk = 0, last_dr = 0;
  bit k_fresh = 1'b0, r_fresh = 1'b0, core_hang = 1'b0;
  logic [127:0] r_val = '0;

  always @(negedge clk) begin
    if (core_load === 1'b1) begin
      k_cnt = $urandom_range(2, 6); last_dk = k_cnt; k_fresh = 1'b1;
    end else if (k_cnt > 0) begin
      if (k_fresh) k_fresh = 1'b0;
      else core_key_ready = (k_cnt == 1);
      k_cnt--;
    end
    if (core_start === 1'b1) begin
      r_cnt = $urandom_range(2, 7); last_dr = r_cnt; r_fresh = 1'b1;
      r_val = sm4_ref(core_key, core_data, core_sel);
    end else if (r_cnt > 0) begin
      if (r_fresh) r_fresh = 1'b0;
      else begin
        core_ready  = (r_cnt == 1) && !core_hang;
        core_result = core_ready ? r_val : {$urandom, $urandom, $urandom, $urandom};
      end
      r_cnt--;
    end
  end

  // Pulse counters for core_load / core_start.
  int load_cnt = 0, start_cnt = 0, overlap = 0;
  always @(negedge clk) begin
    if (core_load === 1'b1) load_cnt++;
    if (core_start === 1'b1) start_cnt++;
    if (core_load === 1'b1 && core_start === 1'b1) overlap++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"},  128'(req_ready), 128'(0));
    chk({tag, "_rsp_valid"},  128'(rsp_valid), 128'(0));
    chk({tag, "_rsp_err"},    128'(rsp_err), 128'(0));
    chk({tag, "_rsp_data"},   rsp_data, '0);
    chk({tag, "_core_pulse"}, 128'({core_load, core_start, core_sel}), 128'(0));
    chk({tag, "_core_data"},  core_data, '0);
    chk({tag, "_core_key"},   core_key, '0);
    chk({tag, "_jobs_done"},  128'(jobs_done), 128'(0));
  endtask

  // One full job: request, latency, result, optional backpressure, handshake.
  task automatic do_job(input logic [127:0] key, input logic [127:0] din, input logic dec,
                        input int hold, output logic [127:0] got);
    logic [127:0] exp_res, snap;
    int n, l0, s0;
    bit busy_ok, stable_ok;
    exp_res = sm4_ref(key, din, dec);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("job_req_ready", 128'(req_ready), 128'(1));
    l0 = load_cnt; s0 = start_cnt;
    req_valid = 1'b1; req_key = key; req_data = din; req_decrypt = dec;
    @(negedge clk);
    req_key = {$urandom, $urandom, $urandom, $urandom};
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_decrypt = 1'($urandom);
    n = 0; busy_ok = 1'b1;
    while (rsp_valid !== 1'b1 && n < 300) begin
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      rsp_ready = 1'($urandom); req_valid = 1'($urandom);
      @(negedge clk); n++;
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("job_latency", 128'(n), 128'(last_dk + last_dr + 2));
    chk("job_busy_req_ready_low", 128'(busy_ok), 128'(1));
    chk("job_rsp_err", 128'(rsp_err), 128'(0));
    chk("job_rsp_data", rsp_data, exp_res);
    chk("job_core_operands", {core_data ^ core_key, 127'(0), core_sel},
        {din ^ key, 127'(0), dec});
    snap = rsp_data; stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== snap || req_ready !== 1'b0 || rsp_err !== 1'b0)
        stable_ok = 1'b0;
    end
    req_valid = 1'b0;
    chk("job_backpressure_stable", 128'(stable_ok), 128'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_jobs = exp_jobs + 16'd1;
    chk("job_rsp_valid_drop", 128'(rsp_valid), 128'(0));
    chk("job_next_req_ready", 128'(req_ready), 128'(1));
    chk("job_jobs_done", 128'(jobs_done), 128'(exp_jobs));
    chk("job_load_pulses", 128'(load_cnt - l0), 128'(1));
    chk("job_start_pulses", 128'(start_cnt - s0), 128'(1));
    got = snap;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] got;
    int n;
    bit seen;

    // Reset behaviour, including a request that must be ignored.
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("por_release_req_ready", 128'(req_ready), 128'(1));

    // Known-answer jobs; the decrypt one is held under 20 cycles of backpressure.
    do_job(K0, K0, 1'b0, 0, got);
    chk("kat_encrypt", got, C0);
    do_job(K0, C0, 1'b1, 20, got);
    chk("kat_decrypt", got, K0);

    // Randomized jobs.
    for (int j = 0; j < 8; j++)
      do_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom), $urandom_range(0, 3), got);

    // Reset while the cipher is running.
    req_valid = 1'b1; req_key = K3; req_data = K0; req_decrypt = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (core_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("rst_reached_start", 128'(core_start), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midjob");
    @(negedge clk);
    reset = 1'b0;
    exp_jobs = '0;
    @(negedge clk);
    chk("midjob_release_req_ready", 128'(req_ready), 128'(1));
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
    chk("midjob_no_response", 128'(seen), 128'(0));

    // Back-to-back jobs after the reset.
    do_job(K0, K0, 1'b0, 0, got);
    chk("b2b_first", got, C0);
    do_job(K3, K0, 1'b0, 0, got);
    chk("b2b_second", got, sm4_ref(K3, K0, 1'b0));
    chk("b2b_jobs_done", 128'(jobs_done), 128'(2));

`ifdef SM4_CTRL_WDOG_EN
    // Core that never completes: timeout exactly WDOG cycles after RUN entry.
    core_hang = 1'b1;
    req_valid = 1'b1; req_key = K0; req_data = K0; req_decrypt = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (core_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("wdog_reached_start", 128'(core_start), 128'(1));
    n = 0;
    while (rsp_valid !== 1'b1 && n < WDOG + 50) begin @(negedge clk); n++; end
    chk("wdog_timeout_cycle", 128'(n), 128'(WDOG + 1));
    chk("wdog_rsp_err", 128'(rsp_err), 128'(1));
    chk("wdog_rsp_data", rsp_data, '0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("wdog_jobs_unchanged", 128'(jobs_done), 128'(exp_jobs));
    core_hang = 1'b0;
    do_job(K0, C0, 1'b1, 1, got);
    chk("wdog_recover", got, K0);
`endif

    chk("no_load_start_overlap", 128'(overlap), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
